// File: rtl/pattern_stim_driver.sv
// LFSR stimulus generator and 16-bit MISR response compactor for the merged pattern netlists.
// Optional PATTERN_STIM_RESP_MASK_EN adds resp_mask to exclude response bits from the signature.
module pattern_stim_driver #(
    parameter int unsigned IN_W       = 11,
    parameter int unsigned OUT_W      = 9,
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned CNT_W      = 8
) (
    input  logic               blif_clk_net,
    input  logic               blif_reset_net,
    input  logic               start,
    input  logic [IN_W-1:0]    seed,
    input  logic [CNT_W-1:0]   num_vec,
    output logic [IN_W-1:0]    stim,
    output logic               stim_valid,
    input  logic [OUT_W-1:0]   resp,
`ifdef PATTERN_STIM_RESP_MASK_EN
    input  logic [OUT_W-1:0]   resp_mask,
`endif
    output logic               busy,
    output logic               done,
    output logic [15:0]        signature,
    output logic [CNT_W-1:0]   vec_cnt
);

    localparam int unsigned SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRIVE,
        S_SETTLE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [IN_W-1:0]   lfsr;
    logic [15:0]       sig;
    logic [SC_W-1:0]   settle_cnt;
    logic [CNT_W-1:0]  num_vec_q;
    logic [CNT_W-1:0]  vec_cnt_inc;
    logic [OUT_W-1:0]  resp_eff;
    logic [15:0]       sig_nxt;
    logic [IN_W-1:0]   lfsr_nxt;

`ifdef PATTERN_STIM_RESP_MASK_EN
    assign resp_eff = resp & ~resp_mask;
`else
    assign resp_eff = resp;
`endif

    // MISR x^16+x^15+x^13+x^4+1, LFSR x^11+x^9+1
    assign sig_nxt     = {sig[14:0], sig[15] ^ sig[14] ^ sig[12] ^ sig[3]} ^ 16'(resp_eff);
    assign lfsr_nxt    = {lfsr[IN_W-2:0], lfsr[IN_W-1] ^ lfsr[IN_W-3]};
    assign vec_cnt_inc = vec_cnt + CNT_W'(1);

    always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
        if (blif_reset_net) state <= S_IDLE;
        else                state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_LOAD;
            S_LOAD:    state_nxt = (num_vec == '0) ? S_DONE : S_DRIVE;
            S_DRIVE:   state_nxt = S_SETTLE;
            S_SETTLE:  if (settle_cnt == '0) state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = (vec_cnt_inc == num_vec_q) ? S_DONE : S_DRIVE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
        if (blif_reset_net) begin
            lfsr       <= '0;
            sig        <= '0;
            vec_cnt    <= '0;
            settle_cnt <= '0;
            num_vec_q  <= '0;
            stim       <= '0;
            stim_valid <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    lfsr      <= (seed == '0) ? IN_W'(1) : seed;
                    sig       <= '0;
                    vec_cnt   <= '0;
                    num_vec_q <= num_vec;
                end
                S_DRIVE: begin
                    stim       <= lfsr;
                    stim_valid <= 1'b1;
                    settle_cnt <= SC_W'(SETTLE_CYC - 1);
                end
                S_SETTLE: begin
                    if (settle_cnt != '0) settle_cnt <= settle_cnt - SC_W'(1);
                end
                S_CAPTURE: begin
                    sig     <= sig_nxt;
                    lfsr    <= lfsr_nxt;
                    vec_cnt <= vec_cnt_inc;
                end
                S_DONE: begin
                    stim_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign signature = sig;

endmodule

// File: tb/tb_pattern_stim_driver.sv
// Randomized self-checking bench for pattern_stim_driver against a cycle-schedule reference model.
module tb_pattern_stim_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [10:0] seed;
    logic [7:0]  num_vec;
    logic [10:0] stim;
    logic        stim_valid;
    logic [8:0]  resp;
    logic [8:0]  resp_mask;
    logic        busy;
    logic        done;
    logic [15:0] signature;
    logic [7:0]  vec_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0]  rlog [0:1100];
    logic [10:0] vec  [0:255];

    always #5 clk = ~clk;

    pattern_stim_driver #(
        .IN_W(11),
        .OUT_W(9),
        .SETTLE_CYC(2),
        .CNT_W(8)
    ) dut (
        .blif_clk_net(clk),
        .blif_reset_net(rst),
        .start(start),
        .seed(seed),
        .num_vec(num_vec),
        .stim(stim),
        .stim_valid(stim_valid),
        .resp(resp),
`ifdef PATTERN_STIM_RESP_MASK_EN
        .resp_mask(resp_mask),
`endif
        .busy(busy),
        .done(done),
        .signature(signature),
        .vec_cnt(vec_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [10:0] lfsr_next(input logic [10:0] v);
        int x;
        x = int'(v);
        return 11'(((x * 2) % 2048) + (((x >> 10) ^ (x >> 8)) & 1));
    endfunction

    function automatic logic [15:0] misr(input logic [15:0] s, input logic [8:0] r);
        int x;
        int fb;
        x  = int'(s);
        fb = ((x >> 15) ^ (x >> 14) ^ (x >> 12) ^ (x >> 3)) & 1;
        return 16'((((x * 2) % 65536) + fb) ^ int'(r));
    endfunction

    // One run: cycle 0 is LOAD, vector k occupies cycles 4k+1..4k+4, done in cycle 4n+1 (or 1).
    task automatic run(input logic [10:0] sd, input int n, input bit rnd,
                       input logic [8:0] fixr, input bit extra);
        int          done_j;
        int          ecnt;
        logic [10:0] v;
        logic [15:0] msig;
        bit          exp_valid;
        done_j = (n == 0) ? 1 : 4 * n + 1;
        v = (sd == 11'd0) ? 11'd1 : sd;
        for (int k = 0; k < n; k++) begin
            vec[k] = v;
            v = lfsr_next(v);
        end
        msig = 16'd0;
        @(negedge clk);
        start   = 1'b1;
        seed    = sd;
        num_vec = 8'(n);
        resp    = rnd ? 9'($urandom) : fixr;
        rlog[0] = resp;
        for (int j = 0; j <= done_j + 1; j++) begin
            @(negedge clk);
            start = extra && (j < done_j) && ($urandom_range(0, 2) == 0);
            if (extra && j == done_j) start = 1'b1;
            if (n > 0 && j >= 5 && ((j - 5) % 4) == 0)
                msig = misr(msig, rlog[j] & ~resp_mask);
            exp_valid = (n > 0) && (j >= 2) && (j <= done_j);
            check("done", 32'(done), 32'(j == done_j));
            check("busy", 32'(busy), 32'(j <= done_j));
            check("stim_valid", 32'(stim_valid), 32'(exp_valid));
            if (exp_valid) check("stim", 32'(stim), 32'(vec[(j - 2) / 4]));
            if (j >= 1) begin
                ecnt = (j - 1) / 4;
                if (ecnt > n) ecnt = n;
                check("signature", 32'(signature), 32'(msig));
                check("vec_cnt", 32'(vec_cnt), 32'(ecnt));
            end
            resp        = rnd ? 9'($urandom) : fixr;
            rlog[j + 1] = resp;
        end
        start = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_sig", 32'(signature), 32'(msig));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; seed = '0; num_vec = '0; resp = '0; resp_mask = '0;
        repeat (3) @(negedge clk);
        check("rst_stim", 32'(stim), 32'd0);
        check("rst_valid", 32'(stim_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sig", 32'(signature), 32'd0);
        check("rst_cnt", 32'(vec_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run(11'd0, 2, 1'b1, 9'd0, 1'b0);
        check("seed0_v0", 32'(vec[0]), 32'h001);
        check("seed0_v1", 32'(vec[1]), 32'h002);
        check("seed0_cnt", 32'(vec_cnt), 32'd2);

        run(11'h2A5, 1, 1'b0, 9'h1FF, 1'b0);
        check("sig_1ff", 32'(signature), 32'h01FF);

`ifdef PATTERN_STIM_RESP_MASK_EN
        resp_mask = 9'h0F0;
        run(11'h155, 1, 1'b0, 9'h1FF, 1'b0);
        check("sig_masked", 32'(signature), 32'h010F);
        resp_mask = 9'($urandom);
        run(11'($urandom), 6, 1'b1, 9'd0, 1'b1);
        resp_mask = '0;
`endif

        run(11'($urandom), 0, 1'b1, 9'd0, 1'b0);
        check("zero_sig", 32'(signature), 32'd0);
        check("zero_cnt", 32'(vec_cnt), 32'd0);

        run(11'h3C1, 4, 1'b1, 9'd0, 1'b1);

        for (int r = 0; r < 20; r++)
            run(11'($urandom), $urandom_range(0, 12), 1'b1, 9'd0, 1'($urandom_range(0, 1)));

        run(11'($urandom), 255, 1'b1, 9'd0, 1'b0);
        check("max_cnt", 32'(vec_cnt), 32'd255);

        // Reset in the middle of the second SETTLE cycle of a 5-vector run
        @(negedge clk);
        start = 1'b1; seed = 11'h0AB; num_vec = 8'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_stim", 32'(stim), 32'd0);
        check("mid_rst_valid", 32'(stim_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_sig", 32'(signature), 32'd0);
        check("mid_rst_cnt", 32'(vec_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check("post_rst_busy", 32'(busy), 32'd0);
            check("post_rst_done", 32'(done), 32'd0);
        end

        run(11'($urandom), 3, 1'b1, 9'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pattern_stim_driver.md
Name: pattern_stim_driver

Overview:
- Stimulus/response end for the merged pattern netlists: drives their 11 primary inputs and reads back their 9 primary outputs.
- Generates pseudo-random input vectors with an 11-bit LFSR and holds each vector stable while the netlist's flop pipeline settles.
- Compresses the captured outputs into a 16-bit MISR signature for pass/fail comparison against a golden value.
- Sits beside a merged pattern instance on the same clock/reset, in the bench or in a BIST wrapper.

Parameters:
- IN_W, 11, stimulus width; matches the pattern primary-input count.
- OUT_W, 9, response width; matches the pattern primary-output count; must be ≤ 16.
- SETTLE_CYC, 2, cycles a vector is held before capture; covers the two-flop depth of the left/right merged patterns; must be ≥ 1.
- CNT_W, 8, width of the vector count and vector counter.

Ports:
- blif_clk_net  in  1  clock; all flops use the rising edge.
- blif_reset_net  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; begins a run; ignored while busy.
- seed  in  IN_W  initial LFSR state, sampled in LOAD.
- num_vec  in  CNT_W  number of vectors in the run, sampled in LOAD.
- stim  out  IN_W  vector driven to the pattern primary inputs.
- stim_valid  out  1  high while stim carries a live vector.
- resp  in  OUT_W  pattern primary outputs.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a run completes.
- signature  out  16  MISR value; stable from done until the next LOAD.
- vec_cnt  out  CNT_W  number of vectors captured so far.

Behaviour:
- Reset, asynchronous: state=IDLE, lfsr=0, sig=0, vec_cnt=0, settle counter=0, stim=0, stim_valid=0, busy=0, done=0.
- Reset asserted mid-run aborts the run immediately; no done pulse is issued.
- FSM states: IDLE, LOAD, DRIVE, SETTLE, CAPTURE, DONE.
- IDLE: on start=1, go to LOAD.
- LOAD (1 cycle):
  - lfsr ← seed, with seed=0 replaced by 11'h001;
  - sig ← 0; vec_cnt ← 0; num_vec latched.
  - Next state is DONE if num_vec=0, otherwise DRIVE.
- DRIVE (1 cycle):
  - stim ← lfsr; stim_valid ← 1;
  - settle counter ← SETTLE_CYC−1.
  - Next state SETTLE.
- SETTLE: stim held; counter decrements each cycle; go to CAPTURE in the cycle the counter reads 0.
- CAPTURE (1 cycle):
  - sig ← {sig[14:0], fb} ^ zero-extended resp, where fb = sig[15]^sig[14]^sig[12]^sig[3] (x^16+x^15+x^13+x^4+1);
  - lfsr ← {lfsr[9:0], lfsr[10]^lfsr[8]} (x^11+x^9+1);
  - vec_cnt ← vec_cnt+1.
  - Next state is DONE if vec_cnt+1 = latched num_vec, otherwise DRIVE.
- stim is held constant from DRIVE through CAPTURE. resp is sampled only in CAPTURE.
- Each vector therefore takes SETTLE_CYC+2 cycles.
- DONE (1 cycle): done=1, stim_valid ← 0, next state IDLE. signature and vec_cnt hold until the next LOAD.
- stim keeps its last value after the run; stim_valid marks liveness.
- start while busy is ignored with no effect.
- start in the same cycle as the DONE pulse is also ignored; it is accepted only in IDLE.
- num_vec = 2^CNT_W−1 is the maximum; vec_cnt never wraps within a run.
- The LFSR is never zero in a run, because a zero seed is remapped.

Optional Feature:
- Macro PATTERN_STIM_RESP_MASK_EN.
- When defined: adds input resp_mask (width OUT_W). CAPTURE XORs in (resp & ~resp_mask) instead of resp. Used to exclude X-prone or uninitialised outputs, such as DFF outputs before the first clock.
- When undefined: the port is absent and all response bits are compressed.

Test Plan:
- Reset mid-SETTLE during a run with num_vec=5 → all outputs return to reset values at once. After release, busy=0 and no done pulse appears.
- seed=0, num_vec=2, SETTLE_CYC=2 → first vector 11'h001, second 11'h002. Each held 4 cycles with stim_valid=1. done pulses 1 cycle after the second CAPTURE; vec_cnt=2.
- num_vec=1, resp tied to 9'h1FF → signature=16'h01FF; done asserted exactly 5 cycles after the LOAD cycle.
- num_vec=0 → sequence LOAD→DONE; stim_valid stays 0; signature=0; vec_cnt=0.
- start pulsed during DRIVE, SETTLE and CAPTURE of an active run → run length, signature and vec_cnt are identical to a run with no extra pulses.
- With PATTERN_STIM_RESP_MASK_EN, resp=9'h1FF, resp_mask=9'h0F0, num_vec=1 → signature=16'h010F.
